// File: rtl/inst_decode_pipe_pkg.sv
// Shared decoder types: opcode class / ALU op enums, RV32I opcode and
// funct3/funct7 legality constants, and the decoded-instruction record.
package corePckg;

  typedef enum logic [2:0] {
    eClsAlu, eClsLoad, eClsStore, eClsBranch, eClsJump, eClsUpper, eClsSys
  } tOpClassEnum;

  // ALU op is {alt, funct3} so OP/OP-IMM decode is a straight bit copy
  typedef enum logic [3:0] {
    eArAdd  = 4'b0000, eArSll = 4'b0001, eArSlt = 4'b0010, eArSltu = 4'b0011,
    eArXor  = 4'b0100, eArSrl = 4'b0101, eArOr  = 4'b0110, eArAnd  = 4'b0111,
    eArSub  = 4'b1000, eArSra = 4'b1101, eArNop = 4'b1111
  } tArithEnum;

  localparam logic [6:0] cOpLoad   = 7'b0000011;
  localparam logic [6:0] cOpStore  = 7'b0100011;
  localparam logic [6:0] cOpBranch = 7'b1100011;
  localparam logic [6:0] cOpJalr   = 7'b1100111;
  localparam logic [6:0] cOpJal    = 7'b1101111;
  localparam logic [6:0] cOpImm    = 7'b0010011;
  localparam logic [6:0] cOpOp     = 7'b0110011;
  localparam logic [6:0] cOpLui    = 7'b0110111;
  localparam logic [6:0] cOpAuipc  = 7'b0010111;
  localparam logic [6:0] cOpFence  = 7'b0001111;
  localparam logic [6:0] cOpSystem = 7'b1110011;

  localparam logic [6:0] cF7Base = 7'h00;
  localparam logic [6:0] cF7Alt  = 7'h20;
  localparam logic [2:0] cF3Add  = 3'b000;
  localparam logic [2:0] cF3Sll  = 3'b001;
  localparam logic [2:0] cF3Sr   = 3'b101;
  localparam logic [2:0] cF3Jalr = 3'b000;

  // Legal-funct3 masks, bit n set when funct3==n is a legal encoding
  localparam logic [7:0] cLoadF3Ok   = 8'b0011_0111;
  localparam logic [7:0] cStoreF3Ok  = 8'b0000_0111;
  localparam logic [7:0] cBranchF3Ok = 8'b1111_0011;

  typedef struct packed {
    tOpClassEnum opClass;
    tArithEnum   arith;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        useRs1;
    logic        useRs2;
    logic        writeRd;
    logic        usePc;
    logic        illegal;
  } tDecoded;

endpackage

// File: rtl/inst_decode_pipe_field_decode.sv
// Combinational RV32I/E field decoder: raw instruction -> decoded record.
// Illegal encodings collapse to a flag-free SYS/NOP record with illegal set.
module inst_field_decode
  import corePckg::*;
#(
  parameter int pRv32e = 0
) (
  input  logic [31:0] iInst,
  output tDecoded     oDec
);

  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [31:0] w_immI, w_immS, w_immB, w_immU, w_immJ;
  logic        w_legal;

  assign w_op  = iInst[6:0];
  assign w_f3  = iInst[14:12];
  assign w_f7  = iInst[31:25];
  assign w_rd  = iInst[11:7];
  assign w_rs1 = iInst[19:15];
  assign w_rs2 = iInst[24:20];

  assign w_immI = {{20{iInst[31]}}, iInst[31:20]};
  assign w_immS = {{20{iInst[31]}}, iInst[31:25], iInst[11:7]};
  assign w_immB = {{19{iInst[31]}}, iInst[31], iInst[7], iInst[30:25], iInst[11:8], 1'b0};
  assign w_immU = {iInst[31:12], 12'b0};
  assign w_immJ = {{11{iInst[31]}}, iInst[31], iInst[19:12], iInst[20], iInst[30:21], 1'b0};

  always_comb begin
    oDec         = '0;
    oDec.opClass = eClsSys;
    oDec.arith   = eArNop;
    w_legal      = (iInst[1:0] == 2'b11);
    case (w_op)
      cOpLoad: begin
        w_legal      = w_legal & cLoadF3Ok[w_f3];
        oDec.opClass = eClsLoad;
        oDec.arith   = eArAdd;
        oDec.rs1     = w_rs1;
        oDec.rd      = w_rd;
        oDec.funct3  = w_f3;
        oDec.imm     = w_immI;
        oDec.useRs1  = 1'b1;
        oDec.writeRd = (w_rd != 5'd0);
      end
      cOpStore: begin
        w_legal      = w_legal & cStoreF3Ok[w_f3];
        oDec.opClass = eClsStore;
        oDec.arith   = eArAdd;
        oDec.rs1     = w_rs1;
        oDec.rs2     = w_rs2;
        oDec.funct3  = w_f3;
        oDec.imm     = w_immS;
        oDec.useRs1  = 1'b1;
        oDec.useRs2  = 1'b1;
      end
      cOpBranch: begin
        w_legal      = w_legal & cBranchF3Ok[w_f3];
        oDec.opClass = eClsBranch;
        oDec.rs1     = w_rs1;
        oDec.rs2     = w_rs2;
        oDec.funct3  = w_f3;
        oDec.imm     = w_immB;
        oDec.useRs1  = 1'b1;
        oDec.useRs2  = 1'b1;
      end
      cOpJalr: begin
        w_legal      = w_legal & (w_f3 == cF3Jalr);
        oDec.opClass = eClsJump;
        oDec.arith   = eArAdd;
        oDec.rs1     = w_rs1;
        oDec.rd      = w_rd;
        oDec.imm     = w_immI;
        oDec.useRs1  = 1'b1;
        oDec.writeRd = (w_rd != 5'd0);
        oDec.usePc   = 1'b1;
      end
      cOpJal: begin
        oDec.opClass = eClsJump;
        oDec.arith   = eArAdd;
        oDec.rd      = w_rd;
        oDec.imm     = w_immJ;
        oDec.writeRd = (w_rd != 5'd0);
        oDec.usePc   = 1'b1;
      end
      cOpLui, cOpAuipc: begin
        oDec.opClass = eClsUpper;
        oDec.arith   = (w_op == cOpAuipc) ? eArAdd : eArNop;
        oDec.rd      = w_rd;
        oDec.imm     = w_immU;
        oDec.writeRd = (w_rd != 5'd0);
        oDec.usePc   = (w_op == cOpAuipc);
      end
      cOpImm: begin
        oDec.opClass = eClsAlu;
        oDec.rs1     = w_rs1;
        oDec.rd      = w_rd;
        oDec.funct3  = w_f3;
        oDec.useRs1  = 1'b1;
        oDec.writeRd = (w_rd != 5'd0);
        // shift-immediates carry shamt, and only right shifts honour the alt bit
        if (w_f3 == cF3Sll) begin
          w_legal    = w_legal & (w_f7 == cF7Base);
          oDec.imm   = {27'b0, w_rs2};
          oDec.arith = eArSll;
        end else if (w_f3 == cF3Sr) begin
          w_legal    = w_legal & ((w_f7 == cF7Base) || (w_f7 == cF7Alt));
          oDec.imm   = {27'b0, w_rs2};
          oDec.arith = tArithEnum'({iInst[30], w_f3});
        end else begin
          oDec.imm   = w_immI;
          oDec.arith = tArithEnum'({1'b0, w_f3});
        end
      end
      cOpOp: begin
        w_legal      = w_legal & ((w_f7 == cF7Base) ||
                       ((w_f7 == cF7Alt) && ((w_f3 == cF3Add) || (w_f3 == cF3Sr))));
        oDec.opClass = eClsAlu;
        oDec.arith   = tArithEnum'({iInst[30], w_f3});
        oDec.rs1     = w_rs1;
        oDec.rs2     = w_rs2;
        oDec.rd      = w_rd;
        oDec.funct3  = w_f3;
        oDec.useRs1  = 1'b1;
        oDec.useRs2  = 1'b1;
        oDec.writeRd = (w_rd != 5'd0);
      end
      cOpFence, cOpSystem: begin
        oDec.funct3 = w_f3;
      end
      default: w_legal = 1'b0;
    endcase

    if ((pRv32e != 0) && ((oDec.useRs1 && oDec.rs1[4]) || (oDec.useRs2 && oDec.rs2[4]) ||
                          (oDec.writeRd && oDec.rd[4])))
      w_legal = 1'b0;

    if (!w_legal) begin
      oDec         = '0;
      oDec.opClass = eClsSys;
      oDec.arith   = eArNop;
      oDec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/inst_decode_pipe.sv
// Elastic instruction decode pipeline: pStages valid/ready register stages,
// raw inst/pc carried in early stages, decoded fields held in the last one.
module inst_decode_pipe
  import corePckg::*;
#(
  parameter int pXLEN   = 32,
  parameter int pStages = 2,
  parameter int pRv32e  = 0
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iInstValid,
  output logic             oInstReady,
  input  logic [31:0]      iInst,
  input  logic [pXLEN-1:0] iCurPc,
  input  logic             iFlush,
  output logic             oValid,
  input  logic             iReady,
  output tOpClassEnum      oOpClass,
  output tArithEnum        oArith,
  output logic [4:0]       oRs1Addr,
  output logic [4:0]       oRs2Addr,
  output logic [4:0]       oRdAddr,
  output logic [2:0]       oFunct3,
  output logic [pXLEN-1:0] oImm,
  output logic [pXLEN-1:0] oCurPc,
  output logic             oUseRs1,
  output logic             oUseRs2,
  output logic             oWriteRd,
  output logic             oUsePc,
  output logic             oIllegal
);

  // w_in*[k] is what stage k would capture; w_rdy[k] is stage k's ready
  logic [pStages:0]   w_rdy;
  logic [pStages-1:0] w_vld;
  logic [pStages-1:0] w_inVld;
  logic [31:0]        w_inInst [pStages];
  logic [pXLEN-1:0]   w_inPc   [pStages];
  tDecoded            w_dec;

  tDecoded            r_dec;
  logic [pXLEN-1:0]   r_pc;
  logic               r_outVld;

  assign w_inVld[0]     = iInstValid;
  assign w_inInst[0]    = iInst;
  assign w_inPc[0]      = iCurPc;
  assign w_rdy[pStages] = iReady;

  for (genvar k = 0; k < pStages; k++) begin : g_rdy
    assign w_rdy[k] = ~w_vld[k] | w_rdy[k+1];
  end

  for (genvar k = 0; k < pStages - 1; k++) begin : g_raw
    logic             r_vld;
    logic [31:0]      r_inst;
    logic [pXLEN-1:0] r_rawPc;

    always_ff @(posedge iClk) begin
      if (iRst || iFlush)  r_vld <= 1'b0;
      else if (w_rdy[k])   r_vld <= w_inVld[k];

      if (iRst) begin
        r_inst  <= '0;
        r_rawPc <= '0;
      end else if (!iFlush && w_rdy[k] && w_inVld[k]) begin
        r_inst  <= w_inInst[k];
        r_rawPc <= w_inPc[k];
      end
    end

    assign w_vld[k]      = r_vld;
    assign w_inVld[k+1]  = r_vld;
    assign w_inInst[k+1] = r_inst;
    assign w_inPc[k+1]   = r_rawPc;
  end

  inst_field_decode #(.pRv32e(pRv32e)) u_dec (
    .iInst (w_inInst[pStages-1]),
    .oDec  (w_dec)
  );

  always_ff @(posedge iClk) begin
    if (iRst || iFlush)         r_outVld <= 1'b0;
    else if (w_rdy[pStages-1])  r_outVld <= w_inVld[pStages-1];

    if (iRst) begin
      r_dec <= '0;
      r_pc  <= '0;
    end else if (!iFlush && w_rdy[pStages-1] && w_inVld[pStages-1]) begin
      r_dec <= w_dec;
      r_pc  <= w_inPc[pStages-1];
    end
  end

  assign w_vld[pStages-1] = r_outVld;

  assign oInstReady = w_rdy[0];
  assign oValid     = r_outVld;
  assign oOpClass   = r_dec.opClass;
  assign oArith     = r_dec.arith;
  assign oRs1Addr   = r_dec.rs1;
  assign oRs2Addr   = r_dec.rs2;
  assign oRdAddr    = r_dec.rd;
  assign oFunct3    = r_dec.funct3;
  assign oImm       = {{(pXLEN-31){r_dec.imm[31]}}, r_dec.imm[30:0]};
  assign oCurPc     = r_pc;
  assign oUseRs1    = r_dec.useRs1;
  assign oUseRs2    = r_dec.useRs2;
  assign oWriteRd   = r_dec.writeRd;
  assign oUsePc     = r_dec.usePc;
  assign oIllegal   = r_dec.illegal;

endmodule

// File: doc/inst_decode_pipe.md
Name: inst_decode_pipe

Overview:
- Parametrised, elastic successor to the current instruction decoder.
- Takes fetched RV32I/RV32E instructions plus PC over a valid/ready handshake and decodes opcode class, register addresses, sign-extended immediate, ALU op and operand-use flags.
- Adds illegal-instruction detection, pipeline flush and backpressure; configurable register-stage count.
- Sits between fetch and the register-read/execute stage.

Parameters:
- pXLEN, 32, datapath/PC/immediate width (32 only legal value this generation; immediates sign-extend to pXLEN).
- pStages, 2, pipeline register stages from input to output, legal 1..3.
- pRv32e, 0, 1 = RV32E: any used register address with bit4 set is illegal.

Ports:
- iClk  in  1  clock
- iRst  in  1  synchronous active-high reset
- iInstValid  in  1  input instruction valid
- oInstReady  out  1  decoder can accept input this cycle
- iInst  in  32  raw instruction
- iCurPc  in  pXLEN  PC of iInst
- iFlush  in  1  discard all in-flight and same-cycle input
- oValid  out  1  decoded output valid
- iReady  in  1  downstream accepts output
- oOpClass  out  3  eClsAlu/eClsLoad/eClsStore/eClsBranch/eClsJump/eClsUpper/eClsSys (package enum)
- oArith  out  4  ALU op code (package enum)
- oRs1Addr, oRs2Addr, oRdAddr  out  5 each  register addresses (0 when unused)
- oFunct3  out  3  funct3 (0 when format has none)
- oImm  out  pXLEN  sign-extended immediate (0 for R-type)
- oCurPc  out  pXLEN  PC carried with instruction
- oUseRs1, oUseRs2, oWriteRd, oUsePc  out  1 each  operand/dest use flags; oWriteRd=0 when rd=x0
- oIllegal  out  1  instruction illegal; all use flags 0

Behaviour:
- Reset: all stage valid bits 0; oValid=0, all data outputs 0, oInstReady=1 the cycle after reset deasserts.
- Elastic chain: stage k holds {valid, inst, pc} (final stage holds decoded fields). ready_k = !valid_k | ready_k+1; final stage's downstream ready = iReady. oInstReady = ready_0 (combinational from iReady allowed).
- Transfer at input when iInstValid & oInstReady; at output when oValid & iReady. Output data stable while oValid & !iReady.
- Decode is combinational into the final stage register; earlier stages carry raw inst/pc. Latency with no backpressure = pStages cycles; throughput 1/cycle; capacity = pStages entries, in-order, no drops, no duplicates.
- iFlush: at next edge every valid bit clears; input accepted in the flush cycle is dropped; output not consumed that cycle is lost. iFlush over iRst: reset wins.
- Immediates: I (loads, OP-IMM, JALR), S, B (bit0=0), U (inst[31:12]<<12), J (bit0=0); shift-imm imm = shamt zero-extended.
- oArith = {alt, funct3} for OP/OP-IMM: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111; alt = inst[30] for R-type and SRLI/SRAI only. Loads/stores/AUIPC/JAL/JALR = ADD; LUI/branch/sys = NOP 1111.
- JAL/JALR: oUsePc=1, oWriteRd per rd; AUIPC oUsePc=1.
- Illegal when: inst[1:0]!=11; unknown opcode; load funct3 in {011,110,111}; store funct3>010; branch funct3 in {010,011}; JALR funct3!=0; R-type funct7 not 0x00/0x20, or 0x20 with funct3 not in {000,101}; SLLI funct7!=0; SRLI/SRAI funct7 not 0x00/0x20; pRv32e & used addr[4]. Illegal entries still flow with oValid=1, oOpClass=eClsSys, oArith=NOP.
- FENCE/SYSTEM: eClsSys, legal, no flags.

Decomposition:
- corePckg gains tOpClassEnum, tArithEnum (4-bit codes above), opcode constants, and legal-funct3/funct7 constants.
- One sub-module: inst_field_decode (purely combinational inst -> decoded fields + illegal), instantiated before the final stage.

Test Plan:
- pStages=2, 0xFFF00093 (ADDI x1,x0,-1) -> 2 cycles later oImm=0xFFFFFFFF, rd=1, rs1=0, oArith=0000, oUseRs1=1, oWriteRd=1.
- 0xFE208EE3 (BEQ x1,x2,-4), PC 0x100 -> eClsBranch, oImm=0xFFFFFFFC, rs1=1, rs2=2, oCurPc=0x100, oWriteRd=0.
- 0x4021D193 (SRAI x3,x3,2) -> oArith=1101, oImm=2; same with funct7=0x40 -> oIllegal=1.
- 0x00000000 and 0x0000707F -> oIllegal=1, oValid=1, all flags 0.
- iReady=0, push 3 back-to-back instructions -> 2 accepted, oInstReady=0 on 3rd; release iReady -> 3 outputs in order.
- iFlush with 2 in flight plus input same cycle -> no output afterwards; iRst mid-stream -> oValid=0, outputs 0 next cycle.
